tmr_pipe_adder: RTL and testbench

TMR_PIPE_ADDER -- requirements
Module: tmr_pipe_adder

---
 rtl/tmr_pkg.sv | 22 ++
 rtl/rca_w.sv | 25 ++
 rtl/tmr_pipe_adder.sv | 159 +++++++++++++++
 tb/tb_tmr_pipe_adder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared mode encodings and input-check helpers for the TMR pipelined adder.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_TMR  = 2'd0,
        MODE_DMR  = 2'd1,
        MODE_FAIL = 2'd2
    } mode_t;

    localparam logic [1:0] FAULT_NONE = 2'd3;
    localparam int         CNT_W      = 4;

    function automatic logic onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // Callers zero-extend the operands; the padding cannot change the parity.
    function automatic logic parity_ok(input logic [31:0] a, input logic [31:0] b, input logic par);
        return ^{a, b, par};
    endfunction

endpackage

// File: rtl/rca_w.sv
// Ripple-carry adder, one replica of the voted datapath.
// Combinational, no handshake.
module rca_w #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic [WIDTH:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[WIDTH];
    end

endmodule

// File: rtl/tmr_pipe_adder.sv
// Triple-redundant adder with voting, replica retirement and input checks; latency 2 cycles.
// Both stages stall together while out_valid & ~out_ready; in_ready follows the stage advance.
module tmr_pipe_adder
    import tmr_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int ERR_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             par,
    input  logic [2:0]       ctrl,
    input  logic [2:0]       inj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ok,
    output logic             err_in,
    output logic             err_vote,
    output logic [1:0]       mode,
    output logic [1:0]       fault_id
);

    localparam logic [CNT_W-1:0] THRESH = ERR_THRESH[CNT_W-1:0];

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             err;
        logic [2:0]       inj;
    } s1_t;

    s1_t              s1;
    logic             adv;
    logic [WIDTH:0]   res [3];
    logic [CNT_W-1:0] cnt [3];
    logic [CNT_W-1:0] cnt_nxt [3];
    mode_t            mode_q, mode_nxt;
    logic [1:0]       fault_q, fault_nxt;
    logic [WIDTH:0]   voted;
    logic             vote_err, vote_ok;
    logic             d01, d02, d12, all_diff;
    logic [2:0]       lone;
    logic [1:0]       lo, hi;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign mode     = mode_q;
    assign fault_id = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (adv) begin
            s1.vld <= in_valid;
            if (in_valid) begin
                s1.a   <= a ^ {WIDTH{ctrl[2]}};
                s1.b   <= b ^ {WIDTH{ctrl[1]}};
                s1.cin <= ~ctrl[0];
                s1.err <= ~(onehot3(ctrl) & parity_ok(32'(a), 32'(b), par));
                s1.inj <= inj;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_rep
        logic [WIDTH-1:0] rs;
        logic             rc;
        rca_w #(.WIDTH(WIDTH)) u_rca (
            .a    (s1.a),
            .b    (s1.b),
            .cin  (s1.cin),
            .sum  (rs),
            .cout (rc)
        );
        assign res[g] = {rc, rs ^ {{(WIDTH-1){1'b0}}, s1.inj[g]}};
    end

    assign d01      = res[0] != res[1];
    assign d02      = res[0] != res[2];
    assign d12      = res[1] != res[2];
    assign all_diff = d01 & d02 & d12;
    assign lone     = {d02 & d12 & ~d01, d01 & d12 & ~d02, d01 & d02 & ~d12};

    always_comb begin
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        fault_nxt = fault_q;
        voted     = res[0];
        vote_err  = 1'b1;
        vote_ok   = 1'b0;
        lo        = 2'd0;
        hi        = 2'd1;
        case (mode_q)
            MODE_TMR: begin
                voted    = (res[0] & res[1]) | (res[0] & res[2]) | (res[1] & res[2]);
                vote_err = d01 | d02 | d12;
                vote_ok  = ~all_diff;
                if (all_diff) begin
                    mode_nxt = MODE_FAIL;
                end else if (!s1.err) begin
                    for (int i = 0; i < 3; i++)
                        if (lone[i] && cnt[i] != '1) cnt_nxt[i] = cnt[i] + 1'b1;
                    // Descending scan so the lowest index wins a tie.
                    for (int i = 2; i >= 0; i--)
                        if (cnt_nxt[i] >= THRESH) begin
                            mode_nxt  = MODE_DMR;
                            fault_nxt = 2'(i);
                        end
                end
            end
            MODE_DMR: begin
                case (fault_q)
                    2'd0:    begin lo = 2'd1; hi = 2'd2; end
                    2'd1:    begin lo = 2'd0; hi = 2'd2; end
                    default: begin lo = 2'd0; hi = 2'd1; end
                endcase
                voted    = res[lo];
                vote_err = res[lo] != res[hi];
                vote_ok  = ~vote_err;
                if (vote_err) mode_nxt = MODE_FAIL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ok        <= 1'b0;
            err_in    <= 1'b0;
            err_vote  <= 1'b0;
            cnt       <= '{default: '0};
            mode_q    <= MODE_TMR;
            fault_q   <= FAULT_NONE;
        end else if (adv) begin
            out_valid <= s1.vld;
            if (s1.vld) begin
                {cout, sum} <= voted;
                ok          <= vote_ok & ~s1.err;
                err_in      <= s1.err;
                err_vote    <= vote_err;
                cnt         <= cnt_nxt;
                mode_q      <= mode_nxt;
                fault_q     <= fault_nxt;
            end
        end
    end

endmodule

// File: tb/tb_tmr_pipe_adder.sv
// Directed and randomized bench for tmr_pipe_adder with a transaction-level reference model.
module tb_tmr_pipe_adder;

    localparam int W          = 3;
    localparam int ERR_THRESH = 4;
    localparam int MASK       = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, par, out_valid, out_ready;
    logic         cout, ok, err_in, err_vote;
    logic [W-1:0] a, b, sum;
    logic [2:0]   ctrl, inj;
    logic [1:0]   mode, fault_id;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;

    typedef struct {
        int sum;
        int cout;
        int ok;
        int ein;
        int ev;
        int mode;
        int fid;
    } exp_t;

    exp_t q[$];
    int   m_mode, m_fid;
    int   m_cnt[3];

    logic [W-1:0] last_sum;
    logic         last_cout, last_ok, last_ein, last_ev;

    always #5 clk = ~clk;

    tmr_pipe_adder #(.WIDTH(W), .ERR_THRESH(ERR_THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .par(par), .ctrl(ctrl), .inj(inj),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ok(ok), .err_in(err_in), .err_vote(err_vote), .mode(mode), .fault_id(fault_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0;
        m_fid  = 3;
        m_cnt  = '{0, 0, 0};
    endtask

    // Reference: each transfer's result under the redundancy policy, in arrival order.
    task automatic model_push(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ip,
                              input logic [2:0] ic, input logic [2:0] ij);
        exp_t e;
        int av, bv, good, outv, maj, lo, hi, j, k;
        int r[3];
        bit ein, all_diff, any_diff, mis;
        av   = ic[2] ? MASK - int'(ia) : int'(ia);
        bv   = ic[1] ? MASK - int'(ib) : int'(ib);
        good = av + bv + (ic[0] ? 0 : 1);
        for (int i = 0; i < 3; i++) r[i] = good ^ int'(ij[i]);
        ein = ($countones(ic) != 1) || ((($countones(ia) + $countones(ib) + int'(ip)) % 2) == 0);
        maj = 0;
        for (int bt = 0; bt <= W; bt++)
            if (((r[0] >> bt) & 1) + ((r[1] >> bt) & 1) + ((r[2] >> bt) & 1) >= 2) maj |= (1 << bt);
        any_diff = (r[0] != r[1]) || (r[0] != r[2]) || (r[1] != r[2]);
        all_diff = (r[0] != r[1]) && (r[0] != r[2]) && (r[1] != r[2]);
        if (m_mode == 0) begin
            outv = maj;
            e.ev = int'(any_diff);
            e.ok = int'(!ein && !all_diff);
            if (all_diff) m_mode = 2;
            else if (!ein)
                for (int i = 0; i < 3; i++) begin
                    j = (i + 1) % 3;
                    k = (i + 2) % 3;
                    if (r[i] != r[j] && r[j] == r[k]) begin
                        if (m_cnt[i] < 15) m_cnt[i]++;
                        if (m_cnt[i] >= ERR_THRESH && m_mode == 0) begin
                            m_mode = 1;
                            m_fid  = i;
                        end
                    end
                end
        end else if (m_mode == 1) begin
            lo   = (m_fid == 0) ? 1 : 0;
            hi   = (m_fid == 2) ? 1 : 2;
            outv = r[lo];
            mis  = r[lo] != r[hi];
            e.ev = int'(mis);
            e.ok = int'(!mis && !ein);
            if (mis) m_mode = 2;
        end else begin
            outv = r[0];
            e.ev = 1;
            e.ok = 0;
        end
        e.sum  = outv & MASK;
        e.cout = (outv >> W) & 1;
        e.ein  = int'(ein);
        e.mode = m_mode;
        e.fid  = m_fid;
        q.push_back(e);
    endtask

    // Called at the falling edge with inputs already driven; returns at the next falling edge.
    task automatic clk_step();
        bit xi, xo;
        #1;
        if (rst_n) chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (q.size() == 0) chk("no_stale_out_valid", out_valid, 0);
        else if (out_valid) begin
            chk("sum", sum, q[0].sum);
            chk("cout", cout, q[0].cout);
            chk("ok", ok, q[0].ok);
            chk("err_in", err_in, q[0].ein);
            chk("err_vote", err_vote, q[0].ev);
            chk("mode", mode, q[0].mode);
            chk("fault_id", fault_id, q[0].fid);
        end
        xi = rst_n && in_valid && in_ready;
        xo = rst_n && out_valid && out_ready;
        if (xo) begin
            last_sum  = sum;
            last_cout = cout;
            last_ok   = ok;
            last_ein  = err_in;
            last_ev   = err_vote;
        end
        @(posedge clk);
        if (xo && q.size() > 0) void'(q.pop_front());
        if (xi) begin
            model_push(a, b, par, ctrl, inj);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 20) begin
            clk_step();
            k++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic xfer(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ip,
                        input logic [2:0] ic, input logic [2:0] ij);
        int acc0 = n_acc;
        int k    = 0;
        in_valid = 1'b1; a = ia; b = ib; par = ip; ctrl = ic; inj = ij;
        while (n_acc == acc0 && k < 20) begin
            clk_step();
            k++;
        end
        chk("xfer_accept", n_acc, acc0 + 1);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic rand_in();
        a    = W'($urandom);
        b    = W'($urandom);
        par  = ~(^a ^ ^b) ^ ($urandom_range(0, 7) == 0);
        ctrl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
        inj  = ($urandom_range(0, 7) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
    endtask

    task automatic rand_stream(input int n, input bit stalls);
        for (int i = 0; i < n; i++) begin
            rand_in();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            clk_step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ok", ok, 0);
        chk("rst_err_in", err_in, 0);
        chk("rst_err_vote", err_vote, 0);
        chk("rst_mode", mode, 0);
        chk("rst_fault_id", fault_id, 3);
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("in_ready_after_release", in_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; par = 1'b0; ctrl = 3'b001; inj = 3'b000;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);

        // Basic add and two-stage latency.
        in_valid = 1'b1; a = 3; b = 2; par = 1'b0; ctrl = 3'b001; inj = 3'b000;
        clk_step();
        in_valid = 1'b0;
        chk("lat_stage1_out_valid", out_valid, 0);
        clk_step();
        chk("lat_stage2_out_valid", out_valid, 1);
        chk("add_sum", sum, 5);
        chk("add_cout", cout, 0);
        chk("add_ok", ok, 1);
        chk("add_err_in", err_in, 0);
        drain();

        // Operand inversion, then bad one-hot (with an injected fault that must not count).
        xfer(3, 2, 1'b0, 3'b100, 3'b000);
        chk("inv_a_sum", last_sum, 7);
        chk("inv_a_cout", last_cout, 0);
        chk("inv_a_ok", last_ok, 1);
        xfer(3, 2, 1'b0, 3'b011, 3'b001);
        chk("bad_onehot_err_in", last_ein, 1);
        chk("bad_onehot_ok", last_ok, 0);
        xfer(3, 2, 1'b1, 3'b001, 3'b000);
        chk("bad_parity_err_in", last_ein, 1);

        // Replica 0 mismatches until retired.
        for (int i = 0; i < 4; i++) begin
            xfer(3, 2, 1'b0, 3'b001, 3'b001);
            chk("tmr_inj_err_vote", last_ev, 1);
            chk("tmr_inj_sum", last_sum, 5);
            chk("tmr_inj_ok", last_ok, 1);
            chk("tmr_inj_mode", mode, (i < 3) ? 0 : 1);
        end
        chk("dmr_fault_id", fault_id, 0);
        xfer(1, 1, 1'b1, 3'b001, 3'b000);
        chk("dmr_clean_sum", last_sum, 2);
        chk("dmr_clean_ok", last_ok, 1);

        // Survivor mismatch drops to FAIL, which persists until reset.
        xfer(3, 2, 1'b0, 3'b001, 3'b010);
        chk("dmr_mis_err_vote", last_ev, 1);
        chk("dmr_mis_ok", last_ok, 0);
        chk("dmr_mis_mode", mode, 2);
        xfer(3, 2, 1'b0, 3'b001, 3'b000);
        chk("fail_sum", last_sum, 5);
        chk("fail_ok", last_ok, 0);
        chk("fail_err_vote", last_ev, 1);
        rand_stream(20, 1'b0);
        drain();
        chk("fail_persist_mode", mode, 2);
        do_reset();

        // Output stall with streaming input.
        out_ready = 1'b0;
        acc0      = n_acc;
        for (int i = 0; i < 5; i++) begin
            rand_in();
            in_valid = 1'b1;
            clk_step();
        end
        chk("stall_in_ready", in_ready, 0);
        chk("stall_accepted", n_acc - acc0, 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        rand_stream(300, 1'b1);
        drain();
        do_reset();

        // Reset while the pipeline is busy.
        for (int i = 0; i < 3; i++) begin
            rand_in();
            in_valid = 1'b1;
            clk_step();
        end
        chk("busy_before_reset", out_valid, 1);
        do_reset();
        repeat (3) clk_step();
        chk("no_valid_after_release", out_valid, 0);

        rand_stream(100, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
